// File: rtl/switch_pkg.sv
// Shared constants and helpers for the push-button reader.
// Contents:
//   CLK_HZ               board clock frequency
//   DEF_DEBOUNCE_CYCLES  10 ms settle window at CLK_HZ
//   DEF_HOLD_CYCLES      1 s long-press window at CLK_HZ
//   cnt_width()          counter width needed to count n cycles
package switch_pkg;

  localparam int CLK_HZ              = 25_000_000;
  localparam int DEF_DEBOUNCE_CYCLES = CLK_HZ / 100;
  localparam int DEF_HOLD_CYCLES     = CLK_HZ;

  // ceil(log2(n)), never below 1 so tiny counts still get a real counter
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/switch_debounce_reader_channel.sv
// One switch channel: 2-flop synchroniser, counter debouncer, registered
// rise/fall pulses and an optional long-press detector.
// Build option: SWITCH_DEBOUNCE_READER_HOLD_EN enables the hold counter;
// without it `hold` is constant 0.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   sw         raw asynchronous switch input (1 = pressed)
//   level      debounced level
//   rise/fall  one-cycle pulses on debounced 0->1 / 1->0
//   rise_next  combinational: rise will be high after the coming edge
//   hold       one-cycle long-press pulse
module debounce_channel
  import switch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic rise_next,
  output logic hold
);

  localparam int            DW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          s1, s2;
  logic [DW-1:0] cnt;
  logic          accept;

  // s2 has disagreed with the accepted level for the full window
  assign accept    = (s2 != level) && (cnt == DB_LAST);
  assign rise_next = accept && s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1   <= sw;
      s2   <= s1;
      rise <= accept && s2;
      fall <= accept && !s2;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef SWITCH_DEBOUNCE_READER_HOLD_EN
  localparam int            HW     = cnt_width(HOLD_CYCLES);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] H_FIRE = HW'(HOLD_CYCLES - 2);

  logic [HW-1:0] hcnt;

  // Saturates at H_LAST, so the pulse fires only on the single step
  // H_FIRE -> H_LAST of each press.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= '0;
      hold <= 1'b0;
    end else begin
      hold <= level && (hcnt == H_FIRE);
      if (!level)
        hcnt <= '0;
      else if (hcnt != H_LAST)
        hcnt <= hcnt + 1'b1;
    end
  end
`else
  assign hold = 1'b0;
`endif

endmodule

// File: rtl/switch_debounce_reader.sv
// Go Board push-button reader: N_SW independent debounced channels plus
// a toggle bit per switch and a global accepted-press counter.
// Build option: SWITCH_DEBOUNCE_READER_HOLD_EN enables SW_HOLD pulses.
// Ports:
//   CLK, RST     25 MHz clock, synchronous active-high reset
//   SW           raw switch inputs, 1 = pressed
//   SW_LEVEL     debounced levels
//   SW_PRESS     one-cycle pulse on debounced press
//   SW_RELEASE   one-cycle pulse on debounced release
//   SW_TOGGLE    flips on each press (same edge as SW_PRESS)
//   PRESS_COUNT  total presses, all channels, one cycle after the pulses
//   SW_HOLD      one-cycle long-press pulse
module switch_debounce_reader
  import switch_pkg::*;
#(
  parameter int N_SW            = 4,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int CNT_W           = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_SW-1:0]  SW,
  output logic [N_SW-1:0]  SW_LEVEL,
  output logic [N_SW-1:0]  SW_PRESS,
  output logic [N_SW-1:0]  SW_RELEASE,
  output logic [N_SW-1:0]  SW_TOGGLE,
  output logic [CNT_W-1:0] PRESS_COUNT,
  output logic [N_SW-1:0]  SW_HOLD
);

  logic [N_SW-1:0]  rise_next;
  logic [CNT_W-1:0] press_sum;

  for (genvar g = 0; g < N_SW; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES)
    ) u_ch (
      .clk       (CLK),
      .rst       (RST),
      .sw        (SW[g]),
      .level     (SW_LEVEL[g]),
      .rise      (SW_PRESS[g]),
      .fall      (SW_RELEASE[g]),
      .rise_next (rise_next[g]),
      .hold      (SW_HOLD[g])
    );
  end

  // popcount of the registered press pulses; wraps naturally at CNT_W
  always_comb begin
    press_sum = '0;
    for (int i = 0; i < N_SW; i++)
      press_sum = press_sum + CNT_W'(SW_PRESS[i]);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      SW_TOGGLE   <= '0;
      PRESS_COUNT <= '0;
    end else begin
      SW_TOGGLE   <= SW_TOGGLE ^ rise_next;
      PRESS_COUNT <= PRESS_COUNT + press_sum;
    end
  end

endmodule

// File: tb/tb_switch_debounce_reader.sv
// Bench for switch_debounce_reader with DEBOUNCE_CYCLES=8, HOLD_CYCLES=32.
// Expected output events are queued when stimulus is driven and checked
// by a negedge monitor on the cycle they are due; all other cycles must
// show no pulses, steady level/toggle and the running press count.
module tb_switch_debounce_reader;
  localparam int N_SW  = 4;
  localparam int DB    = 8;
  localparam int HOLD  = 32;
  localparam int CNT_W = 8;
  // drive after edge k-1 -> s1 captures at k -> level flips at k+DB+1
  localparam int LAT   = DB + 2;

  logic             CLK = 1'b0;
  logic             RST;
  logic [N_SW-1:0]  SW;
  logic [N_SW-1:0]  SW_LEVEL, SW_PRESS, SW_RELEASE, SW_TOGGLE, SW_HOLD;
  logic [CNT_W-1:0] PRESS_COUNT;

  always #5 CLK = ~CLK;

  switch_debounce_reader #(
    .N_SW(N_SW), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RST(RST), .SW(SW), .SW_LEVEL(SW_LEVEL), .SW_PRESS(SW_PRESS),
    .SW_RELEASE(SW_RELEASE), .SW_TOGGLE(SW_TOGGLE),
    .PRESS_COUNT(PRESS_COUNT), .SW_HOLD(SW_HOLD)
  );

  typedef struct {
    int         cyc;
    logic [3:0] level, press, fall, toggle;
  } evt_t;

  typedef struct {
    logic [3:0] sw;
    int         len;
    logic [3:0] press, fall;
  } vec_t;

  evt_t       evq[$];
  int         holdq[$];
  int         cyc = 0;
  int         n_chk = 0, n_fail = 0;
  logic [3:0] push_level = '0, push_toggle = '0;
  logic [3:0] cur_level = '0, cur_toggle = '0;
  logic [7:0] exp_count = '0, pend = '0;
  vec_t       tbl[9];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // queue the debounced outcome of a drive made right now
  task automatic push(input logic [3:0] p, input logic [3:0] f);
    evt_t e;
    push_level  = (push_level | p) & ~f;
    push_toggle = push_toggle ^ p;
    e.cyc = cyc + LAT; e.level = push_level; e.press = p; e.fall = f;
    e.toggle = push_toggle;
    evq.push_back(e);
  endtask

  task automatic do_reset(input int n);
    check("queue_drained_before_reset", 32'(evq.size() + holdq.size()), 32'd0);
    RST = 1'b1;
    evq.delete(); holdq.delete();
    push_level = '0; push_toggle = '0; cur_level = '0; cur_toggle = '0;
    exp_count = '0; pend = '0;
    step(n);
    check("rst_level", 32'(SW_LEVEL), 32'd0);
    check("rst_count", 32'(PRESS_COUNT), 32'd0);
    RST = 1'b0;
  endtask

  always @(negedge CLK) begin
    logic [15:0] exp_vec;
    logic [3:0]  exp_h;
    if (RST === 1'b0) begin
      exp_count = exp_count + pend;
      pend      = '0;
      while (evq.size() > 0 && evq[0].cyc < cyc) begin
        check("event_missed_due_cycle", 32'(cyc), 32'(evq[0].cyc));
        void'(evq.pop_front());
      end
      exp_vec = {cur_level, 4'b0, 4'b0, cur_toggle};
      if (evq.size() > 0 && evq[0].cyc == cyc) begin
        evt_t e;
        e = evq.pop_front();
        cur_level  = e.level;
        cur_toggle = e.toggle;
        exp_vec    = {e.level, e.press, e.fall, e.toggle};
        pend       = 8'($countones(e.press));
      end
      check("level_press_release_toggle",
            32'({SW_LEVEL, SW_PRESS, SW_RELEASE, SW_TOGGLE}), 32'(exp_vec));
      check("press_count", 32'(PRESS_COUNT), 32'(exp_count));
      exp_h = '0;
      if (holdq.size() > 0 && holdq[0] == cyc) begin
        void'(holdq.pop_front());
        exp_h = 4'b1000;
      end
      check("sw_hold", 32'(SW_HOLD), 32'(exp_h));
    end
  end

  initial begin
    // sw, cycles held, expected press mask, expected release mask
    tbl[0] = '{4'b0001, 12, 4'b0001, 4'b0000};
    tbl[1] = '{4'b0000, 12, 4'b0000, 4'b0001};
    tbl[2] = '{4'b1111, 12, 4'b1111, 4'b0000};
    tbl[3] = '{4'b0000, 12, 4'b0000, 4'b1111};
    tbl[4] = '{4'b0101, 12, 4'b0101, 4'b0000};
    tbl[5] = '{4'b1010, 12, 4'b1010, 4'b0101};
    tbl[6] = '{4'b1011,  5, 4'b0000, 4'b0000};  // 5-cycle glitch on SW[0]
    tbl[7] = '{4'b1010, 12, 4'b0000, 4'b0000};
    tbl[8] = '{4'b0000, 12, 4'b0000, 4'b1010};

    RST = 1'b1;
    SW  = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset_level",   32'(SW_LEVEL),    32'd0);
    check("reset_press",   32'(SW_PRESS),    32'd0);
    check("reset_release", 32'(SW_RELEASE),  32'd0);
    check("reset_toggle",  32'(SW_TOGGLE),   32'd0);
    check("reset_count",   32'(PRESS_COUNT), 32'd0);
    check("reset_hold",    32'(SW_HOLD),     32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;

    for (int i = 0; i < 9; i++) begin
      SW = tbl[i].sw;
      if ((tbl[i].press | tbl[i].fall) != 4'b0) push(tbl[i].press, tbl[i].fall);
      step(tbl[i].len);
    end
    check("table_toggle", 32'(SW_TOGGLE), 32'h1);
    check("table_count",  32'(PRESS_COUNT), 32'd9);

    // bounce on SW[1]: 3-cycle runs never reach the window
    for (int i = 0; i < 40; i++) begin
      SW = {2'b00, ((i / 3) % 2) == 0, 1'b0};
      step(1);
    end
    SW = '0;
    step(12);
    check("bounce_level1", 32'(SW_LEVEL[1]), 32'd0);

    // counter wrap: 64 x 4 simultaneous presses
    do_reset(2);
    for (int k = 0; k < 64; k++) begin
      SW = 4'hF; push(4'hF, 4'h0); step(12);
      SW = 4'h0; push(4'h0, 4'hF); step(12);
      if (k == 62) check("count_252", 32'(PRESS_COUNT), 32'd252);
    end
    check("count_wrap", 32'(PRESS_COUNT), 32'd0);

    // reset 4 cycles into debouncing SW[2]; press must restart from scratch
    do_reset(2);
    SW = 4'b0100;
    step(4);
    do_reset(2);
    push(4'b0100, 4'b0000);
    step(14);
    check("rst_midop_level", 32'(SW_LEVEL), 32'h4);
    SW = 4'b0000; push(4'b0000, 4'b0100); step(12);

    // long press on SW[3]: one hold pulse 31 cycles after the press
    do_reset(2);
    SW = 4'b1000; push(4'b1000, 4'b0000);
`ifdef SWITCH_DEBOUNCE_READER_HOLD_EN
    holdq.push_back(cyc + LAT + HOLD - 1);
`endif
    step(70);
    SW = 4'b0000; push(4'b0000, 4'b1000); step(12);
    // short 20-cycle press: no hold pulse
    SW = 4'b1000; push(4'b1000, 4'b0000); step(20);
    SW = 4'b0000; push(4'b0000, 4'b1000); step(12);

    step(5);
    check("queue_drained_at_end", 32'(evq.size() + holdq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_debounce_reader.md
Name:
switch_debounce_reader

Overview:
- Input-side counterpart to the board LED drivers: reads the Go Board push-buttons (SW1..SW4) and turns them into clean, CLK-synchronous events.
- Per switch: 2-flop synchroniser, then counter-based debouncer, then edge detector.
- Publishes debounced level, one-cycle press/release pulses, a per-switch toggle bit for driving LEDs, and a global press counter.
- Sits between the raw button pins and application logic (mode selection, LED demos) in top-level board designs.

Parameters:
- N_SW, 4, number of switch channels (1..8).
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a new level (10 ms at 25 MHz); must be >= 2.
- HOLD_CYCLES, 25000000, cycles a debounced press must persist to raise a hold event (1 s at 25 MHz); used only with the optional feature.
- CNT_W, 8, width of PRESS_COUNT.

Ports:
- CLK  in  1  25 MHz system clock.
- RST  in  1  synchronous reset, active-high.
- SW  in  N_SW  raw asynchronous switch inputs, 1 = pressed.
- SW_LEVEL  out  N_SW  debounced level per switch.
- SW_PRESS  out  N_SW  one-cycle pulse on debounced 0->1.
- SW_RELEASE  out  N_SW  one-cycle pulse on debounced 1->0.
- SW_TOGGLE  out  N_SW  flips on every press; suitable to drive LEDs directly.
- PRESS_COUNT  out  CNT_W  total accepted presses, all channels.
- SW_HOLD  out  N_SW  one-cycle long-press pulse (tied 0 without the optional feature).

Behaviour:
- Interface: single clock CLK; reset RST is synchronous and active-high.
- Reset: all synchroniser flops, debounce counters, SW_LEVEL, SW_PRESS, SW_RELEASE, SW_TOGGLE, PRESS_COUNT and SW_HOLD go to 0 on the first CLK edge with RST=1, and stay 0 while RST=1.
- Synchroniser: two flops per channel (s1 <= SW; s2 <= s1). The debouncer sees only s2.
- Debouncer, per channel: state is `stable` (= SW_LEVEL) plus counter `cnt`, sized ceil(log2(DEBOUNCE_CYCLES)).
  - If s2 == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= s2, cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any glitch shorter than DEBOUNCE_CYCLES consecutive cycles clears cnt and is never reported.
- Latency: a clean SW change sampled into s1 at edge E makes SW_LEVEL change at edge E+1+DEBOUNCE_CYCLES. Equivalently, there are DEBOUNCE_CYCLES+1 edges after s1 captures.
- Event outputs are registered on the same edge as the SW_LEVEL flip and high for exactly one cycle:
  - SW_PRESS on 0->1; SW_RELEASE on 1->0.
  - SW_TOGGLE[i] inverts on the same edge as SW_PRESS[i].
  - PRESS_COUNT increases by popcount(SW_PRESS) on the next edge, i.e. one cycle after the pulses. It wraps modulo 2^CNT_W (255 -> 0 with CNT_W=8). Simultaneous presses on k channels add k.
- Channels are fully independent; the same-cycle press on one channel and release on another is legal.
- Reset mid-debounce: the pending count is discarded. A switch held through reset release is seen as a new press after the full latency.

Optional Feature:
- Macro: SWITCH_DEBOUNCE_READER_HOLD_EN.
- Defined: a per-channel hold counter clears whenever SW_LEVEL=0 and counts while SW_LEVEL=1, saturating.
  - When it reaches HOLD_CYCLES-1, SW_HOLD[i] pulses one cycle, once per press.
  - Releasing before that point produces no hold pulse. Reset clears the counter.
- Undefined: no hold counters are synthesised; SW_HOLD is constant 0.

Decomposition:
- Shared package switch_pkg:
  - CLK_HZ = 25_000_000.
  - Default DEBOUNCE_CYCLES and HOLD_CYCLES constants.
  - A function computing counter width from a cycle count.
- Sub-module debounce_channel: one channel's synchroniser, debouncer, edge pulses and (optional) hold counter. The top generates N_SW instances and owns SW_TOGGLE and PRESS_COUNT.

Test Plan (bench params: DEBOUNCE_CYCLES=8, HOLD_CYCLES=32, CNT_W=8):
- Reset with SW=4'b0000, RST high 3 cycles -> all outputs 0. Then SW[0]=1 held -> SW_LEVEL[0]=1 and SW_PRESS[0]=1 exactly 9 edges after s1 capture, SW_TOGGLE[0]=1, PRESS_COUNT=1 one cycle later.
- Bounce: SW[1] toggles 1/0 every 3 cycles for 40 cycles, then 0 -> no SW_PRESS[1] or SW_RELEASE[1], SW_LEVEL[1] stays 0.
- Release: after a press is accepted, SW[0]=0 held -> one SW_RELEASE[0] pulse; SW_TOGGLE[0] unchanged.
- Simultaneous: SW=4'b1111 from the same cycle -> four SW_PRESS bits high on the same edge, PRESS_COUNT +4. Repeating 64 press/release cycles -> PRESS_COUNT wraps to 0 on the 256th press.
- Reset mid-op: assert RST 4 cycles into debouncing SW[2]=1, keep SW[2]=1 -> after RST drops, the press is reported a full 9 edges after s1 recapture, never earlier.
- With SWITCH_DEBOUNCE_READER_HOLD_EN: hold SW[3] for 60 cycles after acceptance -> exactly one SW_HOLD[3] pulse, 31 cycles after SW_PRESS[3]. A 20-cycle hold -> no pulse. Without the macro -> SW_HOLD always 0.
